data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 13 +
 rtl/rr_pick2.sv | 24 ++
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } arb_state_t;

  localparam logic CORE = 1'b0;
  localparam logic DMA  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin choice: a lone requester wins, a tie goes to the
// port that was not served last.
import data_mem_arb_pkg::*;

module rr_pick2 (
  input  logic core_req,
  input  logic dma_req,
  input  logic last,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = core_req | dma_req;
    if (core_req && dma_req) begin
      pick = ~last;
    end else if (dma_req) begin
      pick = DMA;
    end else begin
      pick = CORE;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/DMA arbiter for a single-port data memory with zero-wait grants,
// bounded bursts and registered read-data return per port.
import data_mem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic             last_served, last_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             sel_valid, sel_port;
  logic             rr_valid, rr_pick;
  logic             owner, own_req, oth_req;

  rr_pick2 u_rr (
    .core_req (core_req),
    .dma_req  (dma_req),
    .last     (last_served),
    .valid    (rr_valid),
    .pick     (rr_pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= DMA;
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      beat_cnt    <= cnt_nxt;
    end
  end

  // The owner keeps the port until it stops asking or uses up its burst
  // while the other side is waiting; an unopposed owner just restarts its count.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = CORE;
    owner     = (state == OWN_DMA) ? DMA : CORE;
    own_req   = (owner == DMA) ? dma_req : core_req;
    oth_req   = (owner == DMA) ? core_req : dma_req;
    state_nxt = state;
    last_nxt  = last_served;
    cnt_nxt   = beat_cnt;
    unique case (state)
      IDLE: begin
        sel_valid = rr_valid;
        sel_port  = rr_pick;
      end
      OWN_CORE, OWN_DMA: begin
        if (own_req && ((beat_cnt < CNT_MAX) || !oth_req)) begin
          sel_valid = 1'b1;
          sel_port  = owner;
        end else if (oth_req) begin
          sel_valid = 1'b1;
          sel_port  = ~owner;
        end
      end
      default: ;
    endcase
    if (sel_valid) begin
      state_nxt = (sel_port == DMA) ? OWN_DMA : OWN_CORE;
      last_nxt  = sel_port;
      if ((state != IDLE) && (state_nxt == state) && (beat_cnt < CNT_MAX)) begin
        cnt_nxt = beat_cnt + CNT_ONE;
      end else begin
        cnt_nxt = CNT_ONE;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Grants are masked while reset is held so the memory sees no command.
  always_comb begin
    core_gnt      = reset && sel_valid && (sel_port == CORE);
    dma_gnt       = reset && sel_valid && (sel_port == DMA);
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    if (core_gnt) begin
      mem_write     = core_we;
      mem_read      = ~core_we;
      mem_address   = core_addr;
      mem_writedata = core_wdata;
    end else if (dma_gnt) begin
      mem_write     = dma_we;
      mem_read      = ~dma_we;
      mem_address   = dma_addr;
      mem_writedata = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
      core_rdata  <= '0;
      dma_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      dma_rvalid  <= dma_gnt & ~dma_we;
      if (core_gnt && !core_we) begin
        core_rdata <= mem_readdata;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_readdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a grant-history
// reference model with its own copy of memory contents.
`timescale 1ns/1ps

module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata, mem_readdata;

  logic [DW-1:0] env_mem   [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  int            owner, run, last_port;
  logic          exp_rvalid [2];
  logic [DW-1:0] exp_rdata  [2];
  int            n_vec = 0;
  int            n_mis = 0;

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  assign mem_readdata = env_mem[mem_address];

  // Memory behind the arbiter; one process owns it, including its clear.
  initial begin
    for (int i = 0; i < (1<<AW); i++) env_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_write) env_mem[mem_address] <= mem_writedata;
    end
  end

  always @(posedge clk) begin
    if (reset) assert (!(core_gnt && dma_gnt))
      else $error("[TB] FAIL gnt_mutex core_gnt=%0b dma_gnt=%0b", core_gnt, dma_gnt);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner = -1;
    run = 0;
    last_port = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rvalid[p] = 1'b0;
      exp_rdata[p]  = '0;
    end
  endtask

  // Who gets the memory this cycle, from the ownership history and the requests.
  function automatic int modelPick(input logic cr, input logic dr);
    logic mine, theirs;
    if (owner < 0) begin
      if (cr && dr) return (last_port == 1) ? 0 : 1;
      if (cr) return 0;
      if (dr) return 1;
      return -1;
    end
    mine   = (owner == 0) ? cr : dr;
    theirs = (owner == 0) ? dr : cr;
    if (mine && (run < BM || !theirs)) return owner;
    if (theirs) return 1 - owner;
    return -1;
  endfunction

  task automatic applyStimulus(
    input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
    output int obs);
    int            g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req = dr;  dma_we = dw;  dma_addr = da;  dma_wdata = dd;
    #1;
    checkOutput("core_rvalid", 64'(core_rvalid), 64'(exp_rvalid[0]));
    checkOutput("core_rdata", 64'(core_rdata), 64'(exp_rdata[0]));
    checkOutput("dma_rvalid", 64'(dma_rvalid), 64'(exp_rvalid[1]));
    checkOutput("dma_rdata", 64'(dma_rdata), 64'(exp_rdata[1]));
    g   = modelPick(cr, dr);
    obs = core_gnt ? 0 : (dma_gnt ? 1 : -1);
    we  = (g == 0) ? cw : dw;
    a   = (g == 0) ? ca : da;
    d   = (g == 0) ? cd : dd;
    checkOutput("core_gnt", 64'(core_gnt), 64'(g == 0));
    checkOutput("dma_gnt", 64'(dma_gnt), 64'(g == 1));
    checkOutput("gnt_mutex", 64'(core_gnt & dma_gnt), 64'(0));
    checkOutput("mem_write", 64'(mem_write), 64'((g >= 0) && we));
    checkOutput("mem_read", 64'(mem_read), 64'((g >= 0) && !we));
    checkOutput("mem_address", 64'(mem_address), (g >= 0) ? 64'(a) : 64'(0));
    checkOutput("mem_writedata", 64'(mem_writedata), (g >= 0) ? 64'(d) : 64'(0));
    @(posedge clk);
    exp_rvalid[0] = 1'b0;
    exp_rvalid[1] = 1'b0;
    if (g >= 0) begin
      if (we) begin
        model_mem[a] = d;
      end else begin
        exp_rvalid[g] = 1'b1;
        exp_rdata[g]  = model_mem[a];
      end
      if (g == owner) run = (run < BM) ? run + 1 : 1;
      else begin
        owner = g;
        run = 1;
      end
      last_port = g;
    end else begin
      owner = -1;
      run = 0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    core_req = 1'b1; dma_req = 1'b1;
    #1;
    checkOutput("rst_core_gnt", 64'(core_gnt), 64'(0));
    checkOutput("rst_dma_gnt", 64'(dma_gnt), 64'(0));
    checkOutput("rst_mem_read", 64'(mem_read | mem_write), 64'(0));
    checkOutput("rst_core_rdata", 64'(core_rdata), 64'(0));
    checkOutput("rst_dma_rvalid", 64'(dma_rvalid), 64'(0));
    @(negedge clk);
    core_req = 1'b0; dma_req = 1'b0;
    reset = 1'b1;
    modelReset();
  endtask

  initial begin
    int obs;
    for (int i = 0; i < (1<<AW); i++) model_mem[i] = '0;
    modelReset();
    #1;
    checkOutput("init_core_rvalid", 64'(core_rvalid), 64'(0));
    checkOutput("init_state", 64'(dut.state), 64'(IDLE));
    doReset();

    // Write then read back through the core port.
    applyStimulus(1, 1, 10'h010, 32'hDEADBEEF, 0, 0, '0, '0, obs);
    checkOutput("wr_gnt_core", 64'(obs), 64'(0));
    applyStimulus(1, 0, 10'h010, 32'h0, 0, 0, '0, '0, obs);
    #1;
    checkOutput("rd_rvalid", 64'(core_rvalid), 64'(1));
    checkOutput("rd_rdata", 64'(core_rdata), 64'hDEADBEEF);

    // Reset dropped while a core read is being granted.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'h010;
    #1;
    checkOutput("abort_gnt_before", 64'(core_gnt), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_gnt_in_rst", 64'(core_gnt), 64'(0));
    checkOutput("abort_rdata_async", 64'(core_rdata), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    core_req = 1'b0;
    #1;
    checkOutput("abort_rvalid", 64'(core_rvalid), 64'(0));
    checkOutput("abort_rdata", 64'(core_rdata), 64'(0));
    checkOutput("abort_state", 64'(dut.state), 64'(IDLE));
    modelReset();

    // Both ports hammering: alternating bursts of BM beats.
    doReset();
    for (int i = 0; i < 3*BM; i++) begin
      applyStimulus(1, $urandom_range(0,1), AW'($urandom_range(0,15)), $urandom,
                    1, $urandom_range(0,1), AW'($urandom_range(0,15)), $urandom, obs);
      checkOutput("burst_seq", 64'(obs), 64'(((i / BM) % 2 == 0) ? 0 : 1));
    end

    // DMA alone for ten beats: counter wraps, core never granted.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, '0, 1, $urandom_range(0,1), AW'($urandom_range(0,15)), $urandom, obs);
      checkOutput("dma_alone_gnt", 64'(obs), 64'(1));
      #1;
      checkOutput("dma_alone_cnt", 64'(dut.beat_cnt), 64'((i % BM) + 1));
    end

    // Core drops mid-burst with DMA waiting: immediate handover.
    doReset();
    for (int i = 0; i < 2; i++)
      applyStimulus(1, 1, AW'(i), $urandom, 0, 0, '0, '0, obs);
    #1;
    checkOutput("handover_cnt", 64'(dut.beat_cnt), 64'(2));
    applyStimulus(0, 0, '0, '0, 1, 1, 10'h020, $urandom, obs);
    checkOutput("handover_gnt", 64'(obs), 64'(1));
    #1;
    checkOutput("handover_state", 64'(dut.state), 64'(OWN_DMA));

    // Random traffic over a small address window.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0,3) != 0, $urandom_range(0,1), AW'($urandom_range(0,15)), $urandom,
                    $urandom_range(0,3) != 0, $urandom_range(0,1), AW'($urandom_range(0,15)), $urandom, obs);
    end
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, obs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
